// File: rtl/core_pkg.sv
// Shared core package: datapath width, functional-unit status and the
// divider's state encoding.
package core_pkg;

  localparam int XLEN = 32;

  // Most negative two's complement value; the signed-overflow dividend.
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  // Functional-unit status reported to the issue logic.
  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } div_state_e;

endpackage

// File: rtl/nonrestoring_divider.sv
// Iterative radix-2 non-restoring divider (DIV/DIVU/REM/REMU), one quotient
// bit per enabled cycle, with RISC-V divide-by-zero and overflow results.
//
// Handshake: a request is accepted on an enabled edge where start_i is high
// and fu_state_o is FREE; operands are captured on that edge only. Results
// appear on quotient_o/remainder_o together with a valid_o pulse (held
// through a stall in DONE) and stay put until the next accept.
module nonrestoring_divider
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clk_en_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            valid_o,
  output fu_state_e       fu_state_o,
  output div_state_e      dbg_state_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  div_state_e state_q, state_d;

  // Partial remainder is one bit wider than the operands so that the
  // magnitude of MIN_INT (2^(XLEN-1)) and the signed intermediate both fit.
  logic [XLEN:0]    p_q;
  logic [XLEN-1:0]  q_q;         // dividend bits shifting out / quotient bits in
  logic [XLEN-1:0]  d_q;         // divisor magnitude
  logic [XLEN-1:0]  a_raw_q;     // raw dividend, remainder for divide-by-zero
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             div0_q;
  logic             ovf_q;

  // Operand decode for the accept edge.
  logic            dd_neg, dv_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0_in, ovf_in;

  // Shared adder/subtractor.
  logic [XLEN:0] p_sh;
  logic [XLEN:0] add_a;
  logic          add_sub;
  logic [XLEN:0] add_res;

  // Sign-corrected results presented in FIXUP.
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] q_res;
  logic [XLEN-1:0] r_res;

  // Operand magnitudes, result signs and special-case detection at accept.
  always_comb begin
    dd_neg  = signed_i & dividend_i[XLEN-1];
    dv_neg  = signed_i & divisor_i[XLEN-1];
    a_mag   = dd_neg ? -dividend_i : dividend_i;
    b_mag   = dv_neg ? -divisor_i : divisor_i;
    div0_in = (divisor_i == '0);
    ovf_in  = signed_i & (dividend_i == MIN_INT) & (divisor_i == '1);
  end

  // One adder serves both the DIVIDE step and the FIXUP restore.
  always_comb begin
    p_sh = {p_q[XLEN-1:0], q_q[XLEN-1]};
    if (state_q == FIXUP) begin
      add_a   = p_q;
      add_sub = 1'b0;
    end else begin
      add_a   = p_sh;
      add_sub = ~p_q[XLEN];
    end
    add_res = add_sub ? (add_a - {1'b0, d_q}) : (add_a + {1'b0, d_q});
  end

  // Restore a negative final remainder, apply signs, then special overrides.
  always_comb begin
    r_mag = p_q[XLEN] ? add_res[XLEN-1:0] : p_q[XLEN-1:0];
    if (div0_q) begin
      q_res = '1;
      r_res = a_raw_q;
    end else if (ovf_q) begin
      q_res = MIN_INT;
      r_res = '0;
    end else begin
      q_res = q_neg_q ? -q_q : q_q;
      r_res = r_neg_q ? -r_mag : r_mag;
    end
  end

  // State register; reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (div0_in | ovf_in) ? FIXUP : DIVIDE;
      DIVIDE:  if (cnt_q == LAST_ITER) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    valid_o     = (state_q == DONE);
    fu_state_o  = (state_q == IDLE) ? FREE : BUSY;
    dbg_state_o = state_q;
  end

  // Datapath: operand capture, shift/add-subtract iterations, result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      a_raw_q     <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else if (clk_en_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            p_q     <= '0;
            q_q     <= a_mag;
            d_q     <= b_mag;
            a_raw_q <= dividend_i;
            cnt_q   <= '0;
            q_neg_q <= dd_neg ^ dv_neg;
            r_neg_q <= dd_neg;
            div0_q  <= div0_in;
            ovf_q   <= ovf_in;
          end
        end
        DIVIDE: begin
          p_q   <= add_res;
          q_q   <= {q_q[XLEN-2:0], ~add_res[XLEN]};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIXUP: begin
          quotient_o  <= q_res;
          remainder_o <= r_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Testbench for nonrestoring_divider: directed vectors, stalls, abort,
// busy-time requests, back-to-back operation and randomized operands
// checked against an arithmetic reference model.
module tb_nonrestoring_divider;
  import core_pkg::*;

  localparam int NORM_LAT = 34;
  localparam int SPEC_LAT = 2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            clk_en_i = 1'b1;
  logic            start_i = 1'b0;
  logic            signed_i = 1'b0;
  logic [31:0]     dividend_i = '0;
  logic [31:0]     divisor_i = '0;
  logic [31:0]     quotient_o;
  logic [31:0]     remainder_o;
  logic            valid_o;
  fu_state_e       fu_state_o;
  div_state_e      dbg_state_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  nonrestoring_divider dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clk_en_i    (clk_en_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .valid_o     (valid_o),
    .fu_state_o  (fu_state_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and reset.
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: plain integer division with RISC-V special cases.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [31:0] q, r;
    longint sa, sb, sq, sr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end
    return {q, r};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input bit s);
    if (b == 32'd0) return SPEC_LAT;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPEC_LAT;
    return NORM_LAT;
  endfunction

  // Driver: holds start until FREE, then runs one operation to valid_o.
  // lat counts enabled edges from the accept edge (inclusive); tot counts all.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                       input int stall_at, input int stall_len, input bit poke,
                       output logic [31:0] q, output logic [31:0] r,
                       output int lat, output int tot, output int wait_n, output bit to);
    int st_rem;
    bit en;
    st_rem = stall_len;
    to = 1'b0;
    lat = 0;
    tot = 0;
    wait_n = 0;
    dividend_i = a;
    divisor_i = b;
    signed_i = sgn;
    start_i = 1'b1;
    clk_en_i = 1'b1;
    while (fu_state_o != FREE && wait_n < 10) begin
      step();
      wait_n++;
    end
    if (fu_state_o != FREE) to = 1'b1;
    step();
    lat = 1;
    tot = 1;
    start_i = 1'b0;
    dividend_i = $urandom;
    divisor_i = $urandom;
    signed_i = $urandom_range(0, 1);
    while (!valid_o && tot < 200) begin
      start_i = (poke && lat >= 5 && lat <= 7);
      if (lat == stall_at && st_rem > 0) begin
        clk_en_i = 1'b0;
        st_rem--;
      end else begin
        clk_en_i = 1'b1;
      end
      en = clk_en_i;
      step();
      tot++;
      if (en) lat++;
    end
    clk_en_i = 1'b1;
    start_i = 1'b0;
    if (!valid_o) to = 1'b1;
    q = quotient_o;
    r = remainder_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clk_en_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    clk_en_i = 1'b1;
    n_cmp++; if (quotient_o !== 32'd0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd0) begin n_fail++; $display("FAIL reset_r: got %h expected 0", remainder_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_cmp++; if (fu_state_o !== FREE) begin n_fail++; $display("FAIL reset_fu: got %0d expected FREE", fu_state_o); end
    n_cmp++; if (dbg_state_o !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state_o); end
  endtask

  task automatic test_directed();
    logic [31:0] va[8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb[8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    bit          vs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] vq[8] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] vr[8] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd5, 32'd0, 32'h8000_0000, 32'd0};
    int          vl[8] = '{NORM_LAT, NORM_LAT, NORM_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, NORM_LAT, NORM_LAT};
    logic [31:0] q, r;
    int lat, tot, wn;
    bit to;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vs[i], -1, 0, 1'b0, q, r, lat, tot, wn, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL dir%0d_timeout: no valid_o within bound", i); end
      n_cmp++; if (q !== vq[i]) begin n_fail++; $display("FAIL dir%0d_q: got %h expected %h", i, q, vq[i]); end
      n_cmp++; if (r !== vr[i]) begin n_fail++; $display("FAIL dir%0d_r: got %h expected %h", i, r, vr[i]); end
      n_cmp++; if (lat != vl[i]) begin n_fail++; $display("FAIL dir%0d_lat: got %0d expected %0d", i, lat, vl[i]); end
      // valid_o is a single pulse and results hold afterwards.
      step();
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pulse: got %b expected 0", i, valid_o); end
      repeat (2) step();
      n_cmp++; if (quotient_o !== vq[i]) begin n_fail++; $display("FAIL dir%0d_hold: got %h expected %h", i, quotient_o, vq[i]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] q, r;
    int lat, tot, wn;
    bit to;
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 10, 5, 1'b0, q, r, lat, tot, wn, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL stall_timeout: no valid_o within bound"); end
    n_cmp++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stall_q: got %h expected ffffffff", q); end
    n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL stall_r: got %h expected 0", r); end
    n_cmp++; if (lat != NORM_LAT) begin n_fail++; $display("FAIL stall_lat: got %0d expected %0d", lat, NORM_LAT); end
    n_cmp++; if (tot != NORM_LAT + 5) begin n_fail++; $display("FAIL stall_tot: got %0d expected %0d", tot, NORM_LAT + 5); end
    // Stall in DONE keeps valid_o high; the next enabled edge drops it.
    clk_en_i = 1'b0;
    repeat (3) step();
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_done_valid: got %b expected 1", valid_o); end
    clk_en_i = 1'b1;
    step();
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_done_drop: got %b expected 0", valid_o); end
  endtask

  task automatic test_abort();
    bit seen;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    signed_i = 1'b0;
    start_i = 1'b1;
    clk_en_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (10) step();
    rst_i = 1'b1;
    clk_en_i = 1'b0;
    step();
    rst_i = 1'b0;
    clk_en_i = 1'b1;
    n_cmp++; if (fu_state_o !== FREE) begin n_fail++; $display("FAIL abort_fu: got %0d expected FREE", fu_state_o); end
    n_cmp++; if (quotient_o !== 32'd0) begin n_fail++; $display("FAIL abort_q: got %h expected 0", quotient_o); end
    n_cmp++; if (remainder_o !== 32'd0) begin n_fail++; $display("FAIL abort_r: got %h expected 0", remainder_o); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL abort_valid: got valid pulse expected none"); end
  endtask

  task automatic test_busy_start();
    logic [63:0] exp;
    logic [31:0] q, r;
    int lat, tot, wn;
    bit to;
    exp_q.push_back(model(32'd1000, 32'd3, 1'b0));
    do_op(32'd1000, 32'd3, 1'b0, -1, 0, 1'b1, q, r, lat, tot, wn, to);
    exp = exp_q.pop_front();
    n_cmp++; if (to) begin n_fail++; $display("FAIL busy_timeout: no valid_o within bound"); end
    n_cmp++; if ({q, r} !== exp) begin n_fail++; $display("FAIL busy_result: got %h/%h expected %h/%h", q, r, exp[63:32], exp[31:0]); end
    n_cmp++; if (lat != NORM_LAT) begin n_fail++; $display("FAIL busy_lat: got %0d expected %0d", lat, NORM_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    logic [31:0] q, r;
    int lat, tot, wn;
    bit to;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = 32'($urandom_range(1, 500));
      exp_q.push_back(model(a, b, 1'b1));
      do_op(a, b, 1'b1, -1, 0, 1'b0, q, r, lat, tot, wn, to);
      exp = exp_q.pop_front();
      n_cmp++; if (to) begin n_fail++; $display("FAIL b2b%0d_timeout: no valid_o within bound", i); end
      n_cmp++; if ({q, r} !== exp) begin n_fail++; $display("FAIL b2b%0d_result: got %h/%h expected %h/%h", i, q, r, exp[63:32], exp[31:0]); end
      // Previous op left the divider in DONE: exactly one edge back to IDLE.
      if (i > 0) begin
        n_cmp++; if (wn != 1) begin n_fail++; $display("FAIL b2b%0d_gap: got %0d expected 1", i, wn); end
      end
    end
    step();
  endtask

  task automatic test_random();
    logic [63:0] exp;
    logic [31:0] q, r, a, b;
    int lat, tot, wn, el;
    bit to, s;
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 1);
      case (i % 5)
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = 32'($urandom_range(1, 17)); end
        2: begin a = -32'($urandom_range(1, 100000)); b = 32'($urandom_range(1, 1000)); end
        3: begin a = $urandom; b = -32'($urandom_range(1, 1000)); end
        default: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(0, 60)); end
      endcase
      exp_q.push_back(model(a, b, s));
      el = model_lat(a, b, s);
      do_op(a, b, s, -1, 0, 1'b0, q, r, lat, tot, wn, to);
      exp = exp_q.pop_front();
      n_cmp++; if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: no valid_o within bound", i); end
      n_cmp++; if ({q, r} !== exp) begin n_fail++; $display("FAIL rnd%0d_result: %h/%h s=%0d got %h/%h expected %h/%h", i, a, b, s, q, r, exp[63:32], exp[31:0]); end
      n_cmp++; if (lat != el) begin n_fail++; $display("FAIL rnd%0d_lat: got %0d expected %0d", i, lat, el); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_abort();
    test_busy_start();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
